// File: rtl/maze_solve_gen.sv
// Wall-following maze solver sequencer. Issues forward moves and heading changes,
// chooses each new heading from side-opening sensing under a selectable turn policy,
// and reports done/fail with a move limit and a completion watchdog.
module maze_solve_gen #(
  parameter int unsigned HDNG_W   = 12,
  parameter int unsigned MV_CNT_W = 8,
  parameter int unsigned MAX_MV   = 200,
  parameter int unsigned TMO_CYC  = 1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_md,
  input  logic [1:0]          policy,
  input  logic                abort,
  input  logic                lft_opn,
  input  logic                rght_opn,
  input  logic                mv_cmplt,
  input  logic                sol_cmplt,
  output logic                strt_mv,
  output logic                strt_hdng,
  output logic [HDNG_W-1:0]   dsrd_hdng,
  output logic                stp_lft,
  output logic                stp_rght,
  output logic                busy,
  output logic                solved,
  output logic                failed,
  output logic [MV_CNT_W-1:0] mv_cnt
);

  localparam int unsigned         TmrW   = $clog2(TMO_CYC + 1);
  localparam logic [TmrW-1:0]     TmoVal = TmrW'(TMO_CYC);
  localparam logic [MV_CNT_W-1:0] MaxMv  = MV_CNT_W'(MAX_MV);

  typedef enum logic [2:0] {
    StIdle,
    StStrtMv,
    StWaitMv,
    StDecide,
    StStrtHdng,
    StWaitHdng,
    StDone,
    StFail
  } state_e;

  state_e              state_q;
  logic [1:0]          hdng_q;      // 0 = N, 1 = W, 2 = S, 3 = E
  logic                pref_lft_q;
  logic                alt_mode_q;
  logic [TmrW-1:0]     tmr_q;
  logic [MV_CNT_W-1:0] mv_cnt_q;

  logic [TmrW-1:0]     tmr_nxt;
  logic                tmo;
  logic [1:0]          turn;
  logic [1:0]          hdng_nxt;

  // Watchdog fires on the cycle whose increment would reach the limit.
  assign tmr_nxt = tmr_q + TmrW'(1);
  assign tmo     = (tmr_nxt == TmoVal);

  // Turn choice as a counter-clockwise quarter-turn count: left 1, right 3, reverse 2.
  always_comb begin
    turn = 2'd2;
    if (pref_lft_q) begin
      if (lft_opn) begin
        turn = 2'd1;
      end else if (rght_opn) begin
        turn = 2'd3;
      end
    end else begin
      if (rght_opn) begin
        turn = 2'd3;
      end else if (lft_opn) begin
        turn = 2'd1;
      end
    end
    hdng_nxt = hdng_q + turn;
  end

  // Main sequencer: state, heading, preference, move counter and watchdog timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      hdng_q     <= 2'd0;
      pref_lft_q <= 1'b0;
      alt_mode_q <= 1'b0;
      tmr_q      <= '0;
      mv_cnt_q   <= '0;
    end else if (abort) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!cmd_md) begin
            state_q    <= StStrtMv;
            alt_mode_q <= (policy == 2'b10);
            pref_lft_q <= (policy == 2'b01);
            mv_cnt_q   <= '0;
          end
        end
        StStrtMv: begin
          if (mv_cnt_q != '1) begin
            mv_cnt_q <= mv_cnt_q + MV_CNT_W'(1);
          end
          tmr_q   <= '0;
          state_q <= StWaitMv;
        end
        StWaitMv: begin
          if (mv_cmplt) begin
            state_q <= StDecide;
          end else if (tmo) begin
            state_q <= StFail;
          end else begin
            tmr_q <= tmr_nxt;
          end
        end
        StDecide: begin
          if (sol_cmplt) begin
            state_q <= StDone;
          end else if (mv_cnt_q >= MaxMv) begin
            state_q <= StFail;
          end else begin
            hdng_q  <= hdng_nxt;
            state_q <= StStrtHdng;
            // Alternate policy flips preference only after this decision is taken.
            if (alt_mode_q) begin
              pref_lft_q <= ~pref_lft_q;
            end
          end
        end
        StStrtHdng: begin
          tmr_q   <= '0;
          state_q <= StWaitHdng;
        end
        StWaitHdng: begin
          if (mv_cmplt) begin
            state_q <= StStrtMv;
          end else if (tmo) begin
            state_q <= StFail;
          end else begin
            tmr_q <= tmr_nxt;
          end
        end
        StDone, StFail: begin
          if (cmd_md) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Heading index to compass value.
  always_comb begin
    dsrd_hdng = '0;
    unique case (hdng_q)
      2'd0: dsrd_hdng = '0;
      2'd1: dsrd_hdng = {2'b00, {(HDNG_W - 2){1'b1}}};
      2'd2: dsrd_hdng = {1'b0, {(HDNG_W - 1){1'b1}}};
      2'd3: dsrd_hdng = {2'b11, {(HDNG_W - 2){1'b0}}};
      default: dsrd_hdng = '0;
    endcase
  end

  // Moore decodes of state plus preference and counter outputs.
  always_comb begin
    strt_mv   = (state_q == StStrtMv);
    strt_hdng = (state_q == StStrtHdng);
    solved    = (state_q == StDone);
    failed    = (state_q == StFail);
    busy      = !((state_q == StIdle) || (state_q == StDone) || (state_q == StFail));
    stp_lft   = pref_lft_q;
    stp_rght  = ~pref_lft_q;
    mv_cnt    = mv_cnt_q;
  end

endmodule

// File: tb/tb_maze_solve_gen.sv
// Bench for maze_solve_gen: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural model.
module tb_maze_solve_gen;

  localparam int HW   = 12;
  localparam int MVW  = 8;
  localparam int MAXM = 200;
  localparam int TMO  = 10;

  // Model phases
  localparam int PH_IDLE = 0, PH_SMV = 1, PH_WMV = 2, PH_DEC = 3;
  localparam int PH_SHD = 4, PH_WHD = 5, PH_DONE = 6, PH_FAIL = 7;

  logic clk, rst_n, cmd_md, abort, lft_opn, rght_opn, mv_cmplt, sol_cmplt;
  logic [1:0] policy;
  logic strt_mv, strt_hdng, stp_lft, stp_rght, busy, solved, failed;
  logic [HW-1:0] dsrd_hdng;
  logic [MVW-1:0] mv_cnt;

  logic lim_strt_mv, lim_strt_hdng, lim_stp_lft, lim_stp_rght, lim_busy, lim_solved, lim_failed;
  logic [HW-1:0] lim_dsrd_hdng;
  logic [MVW-1:0] lim_mv_cnt;

  int n_chk = 0;
  int n_fail = 0;

  logic [HW-1:0] hd_tab [4];

  // Behavioural model state
  int m_ph, m_h, m_cnt, m_wait;
  bit m_left, m_alt;

  maze_solve_gen #(.HDNG_W(HW), .MV_CNT_W(MVW), .MAX_MV(MAXM), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_md(cmd_md), .policy(policy), .abort(abort),
    .lft_opn(lft_opn), .rght_opn(rght_opn), .mv_cmplt(mv_cmplt), .sol_cmplt(sol_cmplt),
    .strt_mv(strt_mv), .strt_hdng(strt_hdng), .dsrd_hdng(dsrd_hdng), .stp_lft(stp_lft),
    .stp_rght(stp_rght), .busy(busy), .solved(solved), .failed(failed), .mv_cnt(mv_cnt)
  );

  maze_solve_gen #(.HDNG_W(HW), .MV_CNT_W(MVW), .MAX_MV(3), .TMO_CYC(TMO)) dut_lim (
    .clk(clk), .rst_n(rst_n), .cmd_md(cmd_md), .policy(policy), .abort(abort),
    .lft_opn(lft_opn), .rght_opn(rght_opn), .mv_cmplt(mv_cmplt), .sol_cmplt(sol_cmplt),
    .strt_mv(lim_strt_mv), .strt_hdng(lim_strt_hdng), .dsrd_hdng(lim_dsrd_hdng),
    .stp_lft(lim_stp_lft), .stp_rght(lim_stp_rght), .busy(lim_busy), .solved(lim_solved),
    .failed(lim_failed), .mv_cnt(lim_mv_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Quarter turns counter-clockwise chosen from the openings and current preference.
  function automatic int pick_turn(input bit left_first, input logic lo, input logic ro);
    if (left_first) return lo ? 1 : (ro ? 3 : 2);
    return ro ? 3 : (lo ? 1 : 2);
  endfunction

  // Reference model, one step per clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= PH_IDLE; m_h <= 0; m_cnt <= 0; m_left <= 1'b0; m_alt <= 1'b0; m_wait <= 0;
    end else if (abort) begin
      m_ph <= PH_IDLE;
    end else begin
      case (m_ph)
        PH_IDLE: if (!cmd_md) begin
          m_ph <= PH_SMV; m_cnt <= 0;
          m_left <= (policy == 2'b01); m_alt <= (policy == 2'b10);
        end
        PH_SMV: begin
          m_cnt <= (m_cnt < (1 << MVW) - 1) ? m_cnt + 1 : m_cnt;
          m_wait <= 0; m_ph <= PH_WMV;
        end
        PH_WMV, PH_WHD: begin
          if (mv_cmplt) m_ph <= (m_ph == PH_WMV) ? PH_DEC : PH_SMV;
          else if (m_wait + 1 == TMO) m_ph <= PH_FAIL;
          m_wait <= m_wait + 1;
        end
        PH_DEC: begin
          if (sol_cmplt) m_ph <= PH_DONE;
          else if (m_cnt >= MAXM) m_ph <= PH_FAIL;
          else begin
            m_h <= (m_h + pick_turn(m_left, lft_opn, rght_opn)) % 4;
            if (m_alt) m_left <= !m_left;
            m_ph <= PH_SHD;
          end
        end
        PH_SHD: begin m_wait <= 0; m_ph <= PH_WHD; end
        default: if (cmd_md) m_ph <= PH_IDLE;
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("strt_mv", 32'(strt_mv), 32'(m_ph == PH_SMV));
    chk("strt_hdng", 32'(strt_hdng), 32'(m_ph == PH_SHD));
    chk("dsrd_hdng", 32'(dsrd_hdng), 32'(hd_tab[m_h]));
    chk("stp_lft", 32'(stp_lft), 32'(m_left));
    chk("stp_rght", 32'(stp_rght), 32'(!m_left));
    chk("busy", 32'(busy), 32'(!(m_ph == PH_IDLE || m_ph == PH_DONE || m_ph == PH_FAIL)));
    chk("solved", 32'(solved), 32'(m_ph == PH_DONE));
    chk("failed", 32'(failed), 32'(m_ph == PH_FAIL));
    chk("mv_cnt", 32'(mv_cnt), 32'(m_cnt));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cmd_md = 1'b1; abort = 1'b0; mv_cmplt = 1'b0; sol_cmplt = 1'b0;
    lft_opn = 1'b0; rght_opn = 1'b0; policy = 2'b00;
    cyc(2);
    rst_n = 1'b1;
  endtask

  // From IDLE: start a run, leave the bench in the first WAIT_MV cycle.
  task automatic start_run(input logic [1:0] pol);
    policy = pol; cmd_md = 1'b0;
    cyc(2);
  endtask

  // From WAIT_MV: complete the move, leave the bench in the cycle after DECIDE.
  task automatic decide(input logic lo, input logic ro, input logic sc);
    lft_opn = lo; rght_opn = ro; sol_cmplt = sc; mv_cmplt = 1'b1;
    cyc(1);
    mv_cmplt = 1'b0;
    cyc(1);
    sol_cmplt = 1'b0;
  endtask

  // From STRT_HDNG: complete the turn, leave the bench in the next WAIT_MV.
  task automatic finish_turn();
    mv_cmplt = 1'b1;
    cyc(2);
    mv_cmplt = 1'b0;
    cyc(1);
  endtask

  initial begin
    hd_tab[0] = 12'h000; hd_tab[1] = 12'h3FF; hd_tab[2] = 12'h7FF; hd_tab[3] = 12'hC00;
    do_reset();

    // Reset values
    chk("rst_dsrd", 32'(dsrd_hdng), 32'h000);
    chk("rst_mv_cnt", 32'(mv_cnt), 0);
    chk("rst_stp_rght", 32'(stp_rght), 1);
    chk("rst_busy", 32'(busy), 0);

    // Right-first basic run
    policy = 2'b00; cmd_md = 1'b0;
    cyc(1);
    chk("t1_strt_mv", 32'(strt_mv), 1);
    cyc(1);
    chk("t1_mv_cnt1", 32'(mv_cnt), 1);
    decide(1'b0, 1'b1, 1'b0);
    chk("t1_strt_hdng", 32'(strt_hdng), 1);
    chk("t1_hdng_e", 32'(dsrd_hdng), 32'hC00);
    mv_cmplt = 1'b1;
    cyc(2);
    chk("t1_strt_mv2", 32'(strt_mv), 1);
    mv_cmplt = 1'b0;
    cyc(1);
    chk("t1_mv_cnt2", 32'(mv_cnt), 2);

    // Left-first
    do_reset();
    start_run(2'b01);
    decide(1'b1, 1'b1, 1'b0);
    chk("t2_hdng_w", 32'(dsrd_hdng), 32'h3FF);
    chk("t2_stp_lft", 32'(stp_lft), 1);
    finish_turn();
    decide(1'b0, 1'b0, 1'b0);
    chk("t2_reverse", 32'(dsrd_hdng), 32'hC00);

    // Alternating policy
    do_reset();
    start_run(2'b10);
    for (int i = 0; i < 4; i++) begin
      chk("t3_stp_lft", 32'(stp_lft), 32'(i % 2));
      decide(1'b1, 1'b1, 1'b0);
      chk("t3_hdng", 32'(dsrd_hdng), (i % 2 == 1) ? 32'h000 : 32'hC00);
      finish_turn();
    end

    // Solution found, release and restart with retained heading
    decide(1'b1, 1'b1, 1'b0);
    finish_turn();
    decide(1'b1, 1'b1, 1'b1);
    chk("t4_solved", 32'(solved), 1);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_no_hdng", 32'(strt_hdng), 0);
    cmd_md = 1'b1;
    cyc(1);
    chk("t4_idle_solved", 32'(solved), 0);
    cmd_md = 1'b0;
    cyc(2);
    chk("t4_restart_cnt", 32'(mv_cnt), 1);
    chk("t4_hdng_kept", 32'(dsrd_hdng), 32'hC00);

    // Watchdog in WAIT_MV
    cyc(TMO - 1);
    chk("t5_not_yet", 32'(failed), 0);
    cyc(1);
    chk("t5_timeout", 32'(failed), 1);

    // Move limit on the MAX_MV=3 instance
    do_reset();
    start_run(2'b00);
    for (int i = 0; i < 3; i++) begin
      decide(1'b0, 1'b1, 1'b0);
      if (i < 2) finish_turn();
    end
    chk("t6_lim_failed", 32'(lim_failed), 1);
    chk("t6_lim_no_hdng", 32'(lim_strt_hdng), 0);
    chk("t6_main_turns", 32'(strt_hdng), 1);

    // Abort in WAIT_HDNG
    cyc(1);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0; cmd_md = 1'b1;
    chk("t7_abort_busy", 32'(busy), 0);
    chk("t7_abort_hdng", 32'(dsrd_hdng), 32'h3FF);
    chk("t7_abort_cnt", 32'(mv_cnt), 3);
    chk("t7_abort_pulse", 32'(strt_mv | strt_hdng), 0);

    // Asynchronous reset mid-run
    start_run(2'b01);
    decide(1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t8_rst_hdng", 32'(dsrd_hdng), 0);
    chk("t8_rst_cnt", 32'(mv_cnt), 0);
    chk("t8_rst_stp", 32'({stp_lft, stp_rght}), 32'b01);
    chk("t8_rst_pulse", 32'(strt_hdng | busy), 0);
    cyc(1);
    rst_n = 1'b1;

    // Randomized run
    cmd_md = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      cmd_md    = ($urandom_range(7) == 0);
      policy    = 2'($urandom_range(3));
      lft_opn   = 1'($urandom_range(1));
      rght_opn  = 1'($urandom_range(1));
      mv_cmplt  = ($urandom_range(2) == 0);
      sol_cmplt = ($urandom_range(9) == 0);
      abort     = ($urandom_range(39) == 0) && (m_ph != PH_SMV) && (m_ph != PH_SHD);
    end
    abort = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
